// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel/line counters plus active-video select, sync pulses
// and frame markers. Every output is registered and describes the counters it ships with.
module vga_timing_gen #(
    parameter int H_L    = 896,
    parameter int V_L    = 795,
    parameter int WIDTH  = 768,
    parameter int HEIGHT = 683,
    parameter int H_FP   = 24,
    parameter int H_SYNC = 80,
    parameter int V_FP   = 3,
    parameter int V_SYNC = 6,
    parameter bit H_POL  = 1'b0,
    parameter bit V_POL  = 1'b0,
    localparam int HW    = $clog2(H_L),
    localparam int VW    = $clog2(V_L)
) (
    input  logic          CLK,
    input  logic          RST_n,
    input  logic          CE,
    output logic [HW-1:0] H_count,
    output logic [VW-1:0] V_count,
    output logic          SEL,
    output logic          HSYNC,
    output logic          VSYNC,
    output logic          SOL,
    output logic          SOF,
    output logic [15:0]   FRAME_CNT
);

    localparam int H_BP = H_L - WIDTH - H_FP - H_SYNC;
    localparam int V_BP = V_L - HEIGHT - V_FP - V_SYNC;

    if (H_BP < 1) begin : g_hbp_chk
        $error("vga_timing_gen: horizontal back porch must be at least 1");
    end
    if (V_BP < 1) begin : g_vbp_chk
        $error("vga_timing_gen: vertical back porch must be at least 1");
    end

    localparam logic [HW-1:0] H_MAX   = HW'(H_L - 1);
    localparam logic [VW-1:0] V_MAX   = VW'(V_L - 1);
    localparam logic [HW-1:0] H_ACT   = HW'(WIDTH);
    localparam logic [VW-1:0] V_ACT   = VW'(HEIGHT);
    localparam logic [HW-1:0] H_SS    = HW'(WIDTH + H_FP);
    localparam logic [HW-1:0] H_SE    = HW'(WIDTH + H_FP + H_SYNC - 1);
    localparam logic [VW-1:0] V_SS    = VW'(HEIGHT + V_FP);
    localparam logic [VW-1:0] V_SE    = VW'(HEIGHT + V_FP + V_SYNC - 1);

    logic [HW-1:0] h_count_q, h_count_d;
    logic [VW-1:0] v_count_q, v_count_d;
    logic          sel_q, sel_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          sol_q, sol_d;
    logic          sof_q, sof_d;
    logic [15:0]   frame_cnt_q, frame_cnt_d;

    // Decode is taken from the next counter value so flags stay aligned with the counters.
    always_comb begin
        h_count_d   = h_count_q;
        v_count_d   = v_count_q;
        sel_d       = sel_q;
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        sol_d       = sol_q;
        sof_d       = sof_q;
        frame_cnt_d = frame_cnt_q;
        if (CE) begin
            if (h_count_q == H_MAX) begin
                h_count_d = '0;
                if (v_count_q == V_MAX) begin
                    v_count_d   = '0;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end else begin
                    v_count_d = v_count_q + 1'b1;
                end
            end else begin
                h_count_d = h_count_q + 1'b1;
            end
            sel_d   = (h_count_d < H_ACT) && (v_count_d < V_ACT);
            hsync_d = ((h_count_d >= H_SS) && (h_count_d <= H_SE)) ? H_POL : ~H_POL;
            // V only moves on the H wrap, so VSYNC naturally switches at the line boundary
            vsync_d = ((v_count_d >= V_SS) && (v_count_d <= V_SE)) ? V_POL : ~V_POL;
            sol_d   = (h_count_d == '0) && (v_count_d < V_ACT);
            sof_d   = (h_count_d == '0) && (v_count_d == '0);
        end
    end

    // Reset parks the raster in back porch so the first enable starts a clean frame.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            h_count_q   <= H_MAX;
            v_count_q   <= V_MAX;
            sel_q       <= 1'b0;
            hsync_q     <= ~H_POL;
            vsync_q     <= ~V_POL;
            sol_q       <= 1'b0;
            sof_q       <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            h_count_q   <= h_count_d;
            v_count_q   <= v_count_d;
            sel_q       <= sel_d;
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            sol_q       <= sol_d;
            sof_q       <= sof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign H_count   = h_count_q;
    assign V_count   = v_count_q;
    assign SEL       = sel_q;
    assign HSYNC     = hsync_q;
    assign VSYNC     = vsync_q;
    assign SOL       = sol_q;
    assign SOF       = sof_q;
    assign FRAME_CNT = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default-timing instance for reset/line/gating/mid-frame reset,
// small active-high instance for a full frame sweep and polarity.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic ce = 1'b0;
    logic rst_s_n = 1'b1;
    logic ce_s = 1'b0;

    logic [9:0]  h, v;
    logic        sel, hs, vs, sol, sof;
    logic [15:0] fc;

    logic [3:0]  s_h, s_v;
    logic        s_sel, s_hs, s_vs, s_sol, s_sof;
    logic [15:0] s_fc;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    vga_timing_gen dut (
        .CLK(clk), .RST_n(rst_n), .CE(ce),
        .H_count(h), .V_count(v), .SEL(sel), .HSYNC(hs), .VSYNC(vs),
        .SOL(sol), .SOF(sof), .FRAME_CNT(fc)
    );

    vga_timing_gen #(
        .H_L(16), .V_L(12), .WIDTH(8), .HEIGHT(6), .H_FP(2), .H_SYNC(3),
        .V_FP(1), .V_SYNC(2), .H_POL(1'b1), .V_POL(1'b1)
    ) dut_s (
        .CLK(clk), .RST_n(rst_s_n), .CE(ce_s),
        .H_count(s_h), .V_count(s_v), .SEL(s_sel), .HSYNC(s_hs), .VSYNC(s_vs),
        .SOL(s_sol), .SOF(s_sof), .FRAME_CNT(s_fc)
    );

    task automatic test_reset();
        @(negedge clk); @(negedge clk);
        total++; if ({h, v} !== {10'd895, 10'd794}) begin bad++;
            $display("FAIL reset_pos: got h=%0d v=%0d want h=895 v=794", h, v); end
        total++; if ({sel, hs, vs, sol, sof} !== 5'b01100) begin bad++;
            $display("FAIL reset_flags: got sel/hs/vs/sol/sof=%b want 01100", {sel, hs, vs, sol, sof}); end
        total++; if (fc !== 16'd0) begin bad++;
            $display("FAIL reset_fc: got %0d want 0", fc); end
        rst_n = 1'b1; ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        total++; if ({h, v} !== 20'd0) begin bad++;
            $display("FAIL first_ce_pos: got h=%0d v=%0d want 0,0", h, v); end
        total++; if ({sel, hs, vs, sol, sof} !== 5'b11111) begin bad++;
            $display("FAIL first_ce_flags: got sel/hs/vs/sol/sof=%b want 11111", {sel, hs, vs, sol, sof}); end
        total++; if (fc !== 16'd1) begin bad++;
            $display("FAIL first_ce_fc: got %0d want 1", fc); end
        repeat (3) @(negedge clk);
        total++; if ({h, v, sel, sol, sof, fc} !== {20'd0, 3'b111, 16'd1}) begin bad++;
            $display("FAIL hold_at_origin: got h=%0d v=%0d sel=%b sol=%b sof=%b fc=%0d want 0 0 1 1 1 1",
                     h, v, sel, sol, sof, fc); end
    endtask

    task automatic test_line_sweep();
        int pos_bad = 0, hs_bad = 0, sel_cnt = 0;
        ce = 1'b1;
        for (int i = 0; i < 896; i++) begin
            if (h !== 10'(i) || v !== 10'd0) pos_bad++;
            if (hs !== ((i >= 792 && i <= 871) ? 1'b0 : 1'b1)) hs_bad++;
            if (sel === 1'b1) sel_cnt++;
            @(negedge clk);
        end
        ce = 1'b0;
        total++; if (pos_bad != 0) begin bad++;
            $display("FAIL line_pos: got %0d bad positions want 0", pos_bad); end
        total++; if (hs_bad != 0) begin bad++;
            $display("FAIL line_hsync: got %0d bad cycles want 0", hs_bad); end
        total++; if (sel_cnt != 768) begin bad++;
            $display("FAIL line_sel_count: got %0d want 768", sel_cnt); end
        total++; if ({h, v, sol, sof} !== {10'd0, 10'd1, 2'b10}) begin bad++;
            $display("FAIL line_wrap: got h=%0d v=%0d sol=%b sof=%b want 0 1 1 0", h, v, sol, sof); end
    endtask

    task automatic test_ce_gating();
        int adv = 0, iter = 0;
        int eh = 0, ev = 1;
        logic c;
        while (adv < 1792 && iter < 10000) begin
            c = 1'($urandom_range(0, 1));
            ce = c;
            @(negedge clk);
            iter++;
            if (c) begin
                adv++;
                if (eh == 895) begin eh = 0; ev = (ev == 794) ? 0 : ev + 1; end
                else eh = eh + 1;
            end
            total++;
            if (h !== 10'(eh) || v !== 10'(ev) || fc !== 16'd1 || vs !== 1'b1 ||
                sel !== (eh < 768 && ev < 683) ||
                hs !== !(eh >= 792 && eh <= 871) ||
                sol !== (eh == 0 && ev < 683) ||
                sof !== (eh == 0 && ev == 0)) begin
                bad++;
                $display("FAIL ce_gating: ce=%b got h=%0d v=%0d sel=%b hs=%b sol=%b sof=%b fc=%0d want h=%0d v=%0d",
                         c, h, v, sel, hs, sol, sof, fc, eh, ev);
            end
        end
        ce = 1'b0;
        total++; if (adv < 1792) begin bad++;
            $display("FAIL ce_gating_budget: got %0d advances want 1792", adv); end
    endtask

    task automatic test_mid_frame_reset();
        ce = 1'b1;
        repeat (400) @(negedge clk);
        ce = 1'b0;
        total++; if ({h, v} !== {10'd400, 10'd3}) begin bad++;
            $display("FAIL mid_pre: got h=%0d v=%0d want 400 3", h, v); end
        rst_n = 1'b0;
        #1;
        total++; if ({h, v, fc, sel, hs, vs, sof} !== {10'd895, 10'd794, 16'd0, 4'b0110}) begin bad++;
            $display("FAIL mid_async: got h=%0d v=%0d fc=%0d sel=%b hs=%b vs=%b sof=%b want 895 794 0 0 1 1 0",
                     h, v, fc, sel, hs, vs, sof); end
        ce = 1'b1;
        repeat (3) @(negedge clk);
        total++; if ({h, v, fc} !== {10'd895, 10'd794, 16'd0}) begin bad++;
            $display("FAIL mid_hold: got h=%0d v=%0d fc=%0d want 895 794 0", h, v, fc); end
        rst_n = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        total++; if ({h, v, sof, sol, fc} !== {20'd0, 2'b11, 16'd1}) begin bad++;
            $display("FAIL mid_restart: got h=%0d v=%0d sof=%b sol=%b fc=%0d want 0 0 1 1 1", h, v, sof, sol, fc); end
    endtask

    task automatic test_small_frame();
        int shape_bad = 0, hs_cnt = 0, vs_cnt = 0, sel_cnt = 0;
        int eh, ev;
        total++; if ({s_h, s_v, s_sel, s_hs, s_vs, s_sof, s_fc} !== {4'd15, 4'd11, 4'b0000, 16'd0}) begin bad++;
            $display("FAIL small_reset: got h=%0d v=%0d sel=%b hs=%b vs=%b sof=%b fc=%0d want 15 11 0 0 0 0 0",
                     s_h, s_v, s_sel, s_hs, s_vs, s_sof, s_fc); end
        rst_s_n = 1'b1; ce_s = 1'b1;
        @(negedge clk);
        total++; if ({s_h, s_v, s_sof, s_sel, s_fc} !== {8'd0, 2'b11, 16'd1}) begin bad++;
            $display("FAIL small_first: got h=%0d v=%0d sof=%b sel=%b fc=%0d want 0 0 1 1 1",
                     s_h, s_v, s_sof, s_sel, s_fc); end
        for (int i = 0; i < 192; i++) begin
            eh = i % 16; ev = i / 16;
            if (s_h !== 4'(eh) || s_v !== 4'(ev)) shape_bad++;
            if (s_hs !== (eh >= 10 && eh <= 12)) shape_bad++;
            if (s_vs !== (ev >= 7 && ev <= 8)) shape_bad++;
            if (s_sel !== (eh < 8 && ev < 6)) shape_bad++;
            if (s_hs === 1'b1) hs_cnt++;
            if (s_vs === 1'b1) vs_cnt++;
            if (s_sel === 1'b1) sel_cnt++;
            @(negedge clk);
        end
        ce_s = 1'b0;
        total++; if (shape_bad != 0) begin bad++;
            $display("FAIL small_shape: got %0d bad samples want 0", shape_bad); end
        total++; if ({hs_cnt, vs_cnt, sel_cnt} !== {32'd36, 32'd32, 32'd48}) begin bad++;
            $display("FAIL small_counts: got hs=%0d vs=%0d sel=%0d want 36 32 48", hs_cnt, vs_cnt, sel_cnt); end
        total++; if ({s_h, s_v, s_sof, s_fc} !== {8'd0, 1'b1, 16'd2}) begin bad++;
            $display("FAIL small_wrap: got h=%0d v=%0d sof=%b fc=%0d want 0 0 1 2", s_h, s_v, s_sof, s_fc); end
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        rst_s_n = 1'b0;
        test_reset();
        test_line_sweep();
        test_ce_gating();
        test_mid_frame_reset();
        test_small_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
